car_motion_controller: RTL and testbench
========================================

// Module: car_motion_controller
// PURPOSE
//   Drives the lift car between floors and produces the floor-arrival event consumed by the door
//   controller (its edge_in), then holds the car until that controller's door_open has risen and
//   fallen. Sits between the request scheduler (one target floor at a time) and the door controller;
//   enforces the interlock "car never departs while door_open is high".
// PARAMETERS
//   N_FLOORS            12   number of floors, valid floor indices 0..N_FLOORS-1
//   FLOOR_TRAVEL_CYCLES 100  clk cycles to travel one floor (>=1)
//   DOOR_SETTLE_CYCLES  4    max cycles after arrive_pulse for door_open to rise (>=1)
//   FW                  $clog2(N_FLOORS) floor index width (localparam)
// PORTS
//   clk            in   1   system clock, all state on rising edge
//   reset          in   1   asynchronous, active-low; 0 forces reset state immediately
//   req_valid      in   1   target-floor request valid
//   req_floor      in   FW  requested target floor
//   req_ready      out  1   request accepted on clk edge where req_valid & req_ready
//   door_open      in   1   door state from door controller
//   arrive_pulse   out  1   one-cycle pulse on arrival at target (drives door edge_in)
//   current_floor  out  FW  floor car is at / last passed
//   moving         out  1   high while in MOVE
//   dir_up         out  1   travel direction of current/last move (1 = up)
//   req_err        out  1   one-cycle pulse: request rejected, req_floor >= N_FLOORS
//   door_fault     out  1   one-cycle pulse: door_open did not rise within DOOR_SETTLE_CYCLES
// BEHAVIOUR
//   Reset (reset==0): state IDLE, current_floor=0, dir_up=1, travel/settle counters=0, all pulse
//     outputs 0, moving=0. Reset mid-move discards the target; car homes to floor 0.
//   All outputs registered except req_ready = (state==IDLE) & ~door_open.
//   States: IDLE, MOVE, WAIT_OPEN, WAIT_CLOSE.
//   IDLE: on accept (req_valid & req_ready):
//     - req_floor >= N_FLOORS -> req_err=1 next cycle, stay IDLE, nothing latched.
//     - req_floor == current_floor -> arrive_pulse=1 for one cycle, -> WAIT_OPEN.
//     - else latch target, dir_up = (req_floor > current_floor), travel_cnt=0, -> MOVE.
//     req_valid while door_open high: not accepted, no req_err, no state change.
//   MOVE: travel_cnt increments each cycle; at the edge where travel_cnt==FLOOR_TRAVEL_CYCLES-1:
//     travel_cnt=0, current_floor +/-1 per dir_up; if new floor == target, arrive_pulse=1 at that
//     same edge and -> WAIT_OPEN. Arrival latency from accept edge T: arrive_pulse high during
//     cycle after edge T + |target-start|*FLOOR_TRAVEL_CYCLES. req/door inputs ignored in MOVE.
//   WAIT_OPEN: settle_cnt increments; door_open==1 -> WAIT_CLOSE, settle_cnt=0;
//     else if settle_cnt==DOOR_SETTLE_CYCLES-1 -> door_fault=1 one cycle, -> IDLE.
//   WAIT_CLOSE: stay while door_open==1; door_open==0 -> IDLE. No timeout (door controller owns it).
//   current_floor never wraps: saturates logic unneeded since target is validated < N_FLOORS.
//   arrive_pulse never asserted for two consecutive cycles; never asserted with moving==1 next cycle.
// TESTING (N_FLOORS=12, FLOOR_TRAVEL_CYCLES=4, DOOR_SETTLE_CYCLES=3)
//   1. Assert reset low mid-MOVE at floor 5 -> immediately current_floor=0, moving=0, IDLE,
//      req_ready=1 after release with door_open=0.
//   2. Floor 0, request 3 accepted at edge T -> current_floor 1/2/3 at T+4/T+8/T+12, arrive_pulse
//      high exactly one cycle after T+12, dir_up=1; model door_open 1 for 10 cycles -> IDLE after fall.
//   3. Floor 3, request 1 -> dir_up=0, arrive after 8 cycles; request 1 again -> arrive_pulse on the
//      next edge, no movement, moving stays 0.
//   4. Request floor 12 -> req_err one cycle, req_ready stays 1, current_floor unchanged.
//   5. door_open held 1 in IDLE with req_valid=1, req_floor=7 -> req_ready=0, no move for whole hold;
//      release -> accepted next edge.
//   6. After arrive_pulse keep door_open=0 -> door_fault pulses 3 cycles later, state IDLE.

Source files
------------

// File: rtl/car_motion_controller.sv
// Lift car motion controller: travels one floor at a time toward a single accepted target,
// raises a one-cycle arrival event, then holds the car until the door has opened and closed.
module car_motion_controller #(
    parameter  int N_FLOORS            = 12,
    parameter  int FLOOR_TRAVEL_CYCLES = 100,
    parameter  int DOOR_SETTLE_CYCLES  = 4,
    localparam int FW                  = $clog2(N_FLOORS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    input  logic [FW-1:0] req_floor,
    output logic          req_ready,
    input  logic          door_open,
    output logic          arrive_pulse,
    output logic [FW-1:0] current_floor,
    output logic          moving,
    output logic          dir_up,
    output logic          req_err,
    output logic          door_fault
);

    localparam int TW = $clog2(FLOOR_TRAVEL_CYCLES + 1);
    localparam int SW = $clog2(DOOR_SETTLE_CYCLES + 1);
    localparam logic [TW-1:0] TRAVEL_LAST = TW'(FLOOR_TRAVEL_CYCLES - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(DOOR_SETTLE_CYCLES - 1);
    localparam logic [FW:0]   FLOOR_LIMIT = (FW + 1)'(N_FLOORS);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_MOVE       = 2'd1,
        ST_WAIT_OPEN  = 2'd2,
        ST_WAIT_CLOSE = 2'd3
    } state_t;

    state_t        r_state;
    logic [FW-1:0] r_floor;
    logic [FW-1:0] r_target;
    logic          r_dir_up;
    logic [TW-1:0] r_travel_cnt;
    logic [SW-1:0] r_settle_cnt;
    logic          r_arrive;
    logic          r_req_err;
    logic          r_door_fault;
    logic          r_moving;

    state_t        w_state_nxt;
    logic [FW-1:0] w_floor_nxt;
    logic [FW-1:0] w_target_nxt;
    logic          w_dir_nxt;
    logic [TW-1:0] w_travel_nxt;
    logic [SW-1:0] w_settle_nxt;
    logic          w_arrive_nxt;
    logic          w_err_nxt;
    logic          w_fault_nxt;
    logic [FW-1:0] w_step_floor;
    logic          w_req_ready;

    // The interlock: a request is only taken while parked with the door shut.
    assign w_req_ready = (r_state == ST_IDLE) && !door_open;

    // Next-state and next-output computation for the motion FSM.
    always_comb begin
        w_state_nxt  = r_state;
        w_floor_nxt  = r_floor;
        w_target_nxt = r_target;
        w_dir_nxt    = r_dir_up;
        w_travel_nxt = r_travel_cnt;
        w_settle_nxt = r_settle_cnt;
        w_arrive_nxt = 1'b0;
        w_err_nxt    = 1'b0;
        w_fault_nxt  = 1'b0;
        w_step_floor = r_dir_up ? (r_floor + FW'(1)) : (r_floor - FW'(1));
        case (r_state)
            ST_IDLE: begin
                if (req_valid && w_req_ready) begin
                    if ({1'b0, req_floor} >= FLOOR_LIMIT) begin
                        w_err_nxt = 1'b1;
                    end else if (req_floor == r_floor) begin
                        w_arrive_nxt = 1'b1;
                        w_settle_nxt = '0;
                        w_state_nxt  = ST_WAIT_OPEN;
                    end else begin
                        w_target_nxt = req_floor;
                        w_dir_nxt    = (req_floor > r_floor);
                        w_travel_nxt = '0;
                        w_state_nxt  = ST_MOVE;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_MOVE: begin
                if (r_travel_cnt == TRAVEL_LAST) begin
                    w_travel_nxt = '0;
                    w_floor_nxt  = w_step_floor;
                    // Target was range-checked on accept, so stepping cannot run past the shaft.
                    if (w_step_floor == r_target) begin
                        w_arrive_nxt = 1'b1;
                        w_settle_nxt = '0;
                        w_state_nxt  = ST_WAIT_OPEN;
                    end else begin
                        w_state_nxt = ST_MOVE;
                    end
                end else begin
                    w_travel_nxt = r_travel_cnt + TW'(1);
                end
            end
            ST_WAIT_OPEN: begin
                if (door_open) begin
                    w_settle_nxt = '0;
                    w_state_nxt  = ST_WAIT_CLOSE;
                end else if (r_settle_cnt == SETTLE_LAST) begin
                    w_settle_nxt = '0;
                    w_fault_nxt  = 1'b1;
                    w_state_nxt  = ST_IDLE;
                end else begin
                    w_settle_nxt = r_settle_cnt + SW'(1);
                end
            end
            ST_WAIT_CLOSE: begin
                if (!door_open) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_WAIT_CLOSE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset drops any target and homes the car to floor 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_floor      <= '0;
            r_target     <= '0;
            r_dir_up     <= 1'b1;
            r_travel_cnt <= '0;
            r_settle_cnt <= '0;
            r_arrive     <= 1'b0;
            r_req_err    <= 1'b0;
            r_door_fault <= 1'b0;
            r_moving     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_floor      <= w_floor_nxt;
            r_target     <= w_target_nxt;
            r_dir_up     <= w_dir_nxt;
            r_travel_cnt <= w_travel_nxt;
            r_settle_cnt <= w_settle_nxt;
            r_arrive     <= w_arrive_nxt;
            r_req_err    <= w_err_nxt;
            r_door_fault <= w_fault_nxt;
            r_moving     <= (w_state_nxt == ST_MOVE);
        end
    end

    assign req_ready     = w_req_ready;
    assign arrive_pulse  = r_arrive;
    assign current_floor = r_floor;
    assign moving        = r_moving;
    assign dir_up        = r_dir_up;
    assign req_err       = r_req_err;
    assign door_fault    = r_door_fault;

endmodule

// File: tb/tb_car_motion_controller.sv
// Bench for car_motion_controller: table of requests checked through an expectation queue,
// plus hand sequences for the door-held interlock and asynchronous reset mid-travel.
module tb_car_motion_controller;

    localparam int NF  = 12;
    localparam int FTC = 4;
    localparam int DSC = 3;
    localparam int FW  = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic [FW-1:0] req_floor;
    logic          req_ready;
    logic          door_open;
    logic          arrive_pulse;
    logic [FW-1:0] current_floor;
    logic          moving;
    logic          dir_up;
    logic          req_err;
    logic          door_fault;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int tgt;
        int err;
        int exp_floor;
        int exp_dir;
        int lat;
        int door_hold;
    } vec_t;

    typedef struct {
        int err;
        int tgt_floor;
        int dir;
        int lat;
    } exp_t;

    vec_t vecs[7];
    exp_t sb_q[$];

    always #5 clk = ~clk;

    car_motion_controller #(
        .N_FLOORS(NF),
        .FLOOR_TRAVEL_CYCLES(FTC),
        .DOOR_SETTLE_CYCLES(DSC)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_floor(req_floor),
        .req_ready(req_ready),
        .door_open(door_open),
        .arrive_pulse(arrive_pulse),
        .current_floor(current_floor),
        .moving(moving),
        .dir_up(dir_up),
        .req_err(req_err),
        .door_fault(door_fault)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic run_vec(input vec_t v);
        exp_t e;
        exp_t got;
        int   k;
        bit   seen;
        @(negedge clk);
        req_valid = 1'b1;
        req_floor = FW'(v.tgt);
        chk("ready_before_req", req_ready, 1);
        @(posedge clk);
        e.err = v.err; e.tgt_floor = v.exp_floor; e.dir = v.exp_dir; e.lat = v.lat;
        sb_q.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
        if (v.err != 0) begin
            got = sb_q.pop_front();
            chk("req_err_pulse", req_err, 1);
            chk("err_floor_kept", current_floor, got.tgt_floor);
            chk("err_ready", req_ready, 1);
            chk("err_no_move", moving, 0);
            @(negedge clk);
            chk("req_err_single", req_err, 0);
            chk("err_no_arrive", arrive_pulse, 0);
        end else begin
            k = 0;
            seen = 1'b0;
            while (!seen && k < 200) begin
                if (arrive_pulse) begin
                    seen = 1'b1;
                end else begin
                    chk("moving_in_travel", moving, 1);
                    k++;
                    @(negedge clk);
                end
            end
            got = sb_q.pop_front();
            chk("arrive_seen", seen, 1);
            chk("arrive_latency", k, got.lat);
            chk("arrive_floor", current_floor, got.tgt_floor);
            chk("arrive_dir", dir_up, got.dir);
            chk("arrive_not_moving", moving, 0);
            if (v.door_hold > 0) begin
                door_open = 1'b1;
                @(negedge clk);
                chk("arrive_single", arrive_pulse, 0);
                repeat (v.door_hold - 1) @(negedge clk);
                chk("ready_low_door_open", req_ready, 0);
                chk("held_no_move", moving, 0);
                door_open = 1'b0;
                @(negedge clk);
                chk("ready_after_close", req_ready, 1);
                chk("no_fault_after_close", door_fault, 0);
            end else begin
                k = 0;
                seen = 1'b0;
                while (!seen && k < 10) begin
                    @(negedge clk);
                    k++;
                    if (k == 1) chk("arrive_single", arrive_pulse, 0);
                    if (door_fault) seen = 1'b1;
                end
                chk("door_fault_seen", seen, 1);
                chk("door_fault_delay", k, DSC);
                chk("idle_after_fault", req_ready, 1);
                @(negedge clk);
                chk("door_fault_single", door_fault, 0);
            end
        end
    endtask

    initial begin
        int k;
        vecs[0] = '{3,  0, 3,  1, 12, 10};
        vecs[1] = '{1,  0, 1,  0, 8,  2};
        vecs[2] = '{1,  0, 1,  0, 0,  2};
        vecs[3] = '{12, 1, 1,  0, 0,  0};
        vecs[4] = '{11, 0, 11, 1, 40, 0};
        vecs[5] = '{15, 1, 11, 1, 0,  0};
        vecs[6] = '{0,  0, 0,  0, 44, 3};

        reset     = 1'b0;
        req_valid = 1'b0;
        req_floor = '0;
        door_open = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_floor", current_floor, 0);
        chk("rst_dir", dir_up, 1);
        chk("rst_moving", moving, 0);
        chk("rst_arrive", arrive_pulse, 0);
        chk("rst_err", req_err, 0);
        chk("rst_fault", door_fault, 0);
        chk("rst_ready", req_ready, 1);
        reset = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i]);
        end
        chk("scoreboard_empty", sb_q.size(), 0);

        // Door held open in IDLE blocks a valid request for the whole hold.
        @(negedge clk);
        door_open = 1'b1;
        req_valid = 1'b1;
        req_floor = FW'(7);
        repeat (6) begin
            @(negedge clk);
            chk("hold_ready_low", req_ready, 0);
            chk("hold_no_move", moving, 0);
            chk("hold_floor", current_floor, 0);
            chk("hold_no_err", req_err, 0);
        end
        door_open = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        chk("release_accept_moving", moving, 1);
        chk("release_dir", dir_up, 1);

        // Asynchronous reset while travelling past floor 5.
        k = 0;
        while (current_floor != FW'(5) && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("reached_floor5", current_floor, 5);
        chk("moving_at_floor5", moving, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_floor", current_floor, 0);
        chk("async_rst_moving", moving, 0);
        chk("async_rst_dir", dir_up, 1);
        chk("async_rst_ready", req_ready, 1);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_ready", req_ready, 1);
        chk("post_rst_moving", moving, 0);
        chk("post_rst_floor", current_floor, 0);
        chk("post_rst_arrive", arrive_pulse, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
